// File: rtl/lift_pkg.sv
// lift_pkg: shared types and constants for the elevator controller.
//   FLOOR_W    - width of a floor code
//   NO_REQ     - floor code meaning "no request"
//   MAX_FLOORS - largest supported floor count
//   state_e    - call issue FSM states
//   rr_next    - round-robin successor of a floor, wrapping n -> 1
package lift_pkg;

    localparam int unsigned FLOOR_W    = 3;
    localparam logic [FLOOR_W-1:0] NO_REQ = 3'd0;
    localparam int unsigned MAX_FLOORS = 7;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_e;

    function automatic logic [FLOOR_W-1:0] rr_next(input logic [FLOOR_W-1:0] f,
                                                   input int unsigned        n);
        return (f >= FLOOR_W'(n)) ? FLOOR_W'(1) : f + FLOOR_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus tick-sampled debouncer for one button.
//   clk, rst_n - clock, asynchronous active-high reset
//   btn_i      - raw asynchronous button level
//   tick_i     - shared sample strobe
//   rise_o     - one-cycle pulse on the debounced 0->1 transition
module btn_debounce #(
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic tick_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic [2:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;

    // cnt_q counts consecutive samples that disagree with the current level;
    // any agreeing sample restarts the run.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (tick_i) begin
            if (sync_q[1] != level_q) begin
                if (cnt_q == 3'(DEB_SAMPLES - 1)) begin
                    level_d = sync_q[1];
                    cnt_d   = 3'd0;
                    rise_d  = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= 3'd0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/call_encoder.sv
// call_encoder: debounces floor call buttons, keeps pending/issued call sets and issues one
// floor code at a time to the request buffer, round-robin across floors.
//   clk, rst_n           - clock, asynchronous active-high reset (name kept from the codebase)
//   btn[NUM_FLOORS]      - raw call buttons, bit i-1 is floor i
//   q_full               - blocks new issues while high (sampled in IDLE only)
//   arr_valid, arr_floor - car served arr_floor; out-of-range floors are ignored
//   dout                 - floor code for the buffer, 0 when idle
//   lamp[NUM_FLOORS]     - call lamps, pending OR issued
module call_encoder
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = 7,
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  q_full,
    input  logic                  arr_valid,
    input  logic [2:0]            arr_floor,
    output logic [2:0]            dout,
    output logic [NUM_FLOORS-1:0] lamp
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    if (NUM_FLOORS < 1 || NUM_FLOORS > MAX_FLOORS) begin : g_bad_floors
        $error("call_encoder: NUM_FLOORS out of range");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("call_encoder: TICK_DIV must be at least 2");
    end
    if (DEB_SAMPLES < 2 || DEB_SAMPLES > 8) begin : g_bad_deb
        $error("call_encoder: DEB_SAMPLES out of range");
    end

    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic                  tick;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [NUM_FLOORS-1:0] iss_q, iss_d;
    logic [NUM_FLOORS-1:0] lamp_q;
    logic [NUM_FLOORS-1:0] sel_mask, arr_mask;
    logic [FLOOR_W-1:0]    sel_q, sel_d;
    logic [FLOOR_W-1:0]    last_q, last_d;
    logic [FLOOR_W-1:0]    win, cand;
    logic                  win_vld;
    state_e                state_q, state_d;

    // Shared sample strobe for all debouncers.
    assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_deb
        btn_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn[i]),
            .tick_i(tick),
            .rise_o(press[i])
        );
    end

    // Decode sel and arrival floor into per-floor masks; codes outside 1..NUM_FLOORS
    // match no bit, which is how invalid arrivals get ignored.
    always_comb begin
        sel_mask = '0;
        arr_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            sel_mask[i] = (sel_q == FLOOR_W'(i + 1));
            arr_mask[i] = arr_valid && (arr_floor == FLOOR_W'(i + 1));
        end
    end

    // Round-robin search starting at last+1, first pending floor wins.
    always_comb begin
        win     = NO_REQ;
        win_vld = 1'b0;
        cand    = last_q;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            cand = rr_next(cand, NUM_FLOORS);
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!win_vld && pend_q[i] && (cand == FLOOR_W'(i + 1))) begin
                    win     = cand;
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        pend_d  = pend_q;
        iss_d   = iss_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld && !q_full) begin
                    sel_d   = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pend_d  = pend_d & ~sel_mask;
                iss_d   = iss_d | sel_mask;
                last_d  = sel_q;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A press is accepted only for a floor that is neither pending nor issued.
        pend_d = pend_d | (press & ~pend_q & ~iss_q);
        // Arrival is applied last so it beats both a same-cycle press and issue.
        pend_d = pend_d & ~arr_mask;
        iss_d  = iss_d & ~arr_mask;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            sel_q      <= NO_REQ;
            last_q     <= FLOOR_W'(NUM_FLOORS);
            pend_q     <= '0;
            iss_q      <= '0;
            lamp_q     <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            iss_q      <= iss_d;
            lamp_q     <= pend_d | iss_d;
        end
    end

    assign dout = (state_q == ISSUE) ? sel_q : NO_REQ;
    assign lamp = lamp_q;

endmodule

// File: tb/tb_call_encoder.sv
module tb_call_encoder;

    logic       clk;
    logic       rst_n;
    logic [5:0] btn;
    logic       q_full;
    logic       arr_valid;
    logic [2:0] arr_floor;
    logic [2:0] dout;
    logic [5:0] lamp;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] exp_q[$];

    call_encoder #(
        .NUM_FLOORS (6),
        .TICK_DIV   (4),
        .DEB_SAMPLES(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .q_full   (q_full),
        .arr_valid(arr_valid),
        .arr_floor(arr_floor),
        .dout     (dout),
        .lamp     (lamp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every nonzero dout cycle pops one expected code; codes must be
    // separated by at least one zero cycle.
    initial begin : monitor
        logic [2:0] e;
        bit         prev_nz;
        prev_nz = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b0) begin
                prev_nz = 1'b0;
            end else begin
                if (dout !== 3'd0) begin
                    tests_run++;
                    if (prev_nz) begin
                        tests_failed++;
                        $display("FAIL code_gap: dout=%0d right after a nonzero code, required 0",
                                 dout);
                    end
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_issue: dout=%0d, required 0", dout);
                    end else begin
                        e = exp_q.pop_front();
                        if (dout !== e) begin
                            tests_failed++;
                            $display("FAIL issue_order: dout=%0d, required %0d", dout, e);
                        end
                    end
                end
                prev_nz = (dout !== 3'd0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arrive(input logic [2:0] f);
        arr_valid = 1'b1;
        arr_floor = f;
        cyc(1);
        arr_valid = 1'b0;
        arr_floor = 3'd0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic test_reset;
        bit found;
        int nz;
        int bad_lamp;
        tests_run++;
        if (dout !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_dout: dout=%0d, required 0", dout);
        end
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_lamp: lamp=%b, required 000000", lamp);
        end
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        btn[0] = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (dout === 3'd1) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL first_issue: dout never 1 within 80 cycles, required 1");
        end
        // Reset lands mid-issue, before the monitor samples this cycle.
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (dout !== 3'd0) begin
            tests_failed++;
            $display("FAIL midissue_reset_dout: dout=%0d, required 0", dout);
        end
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL midissue_reset_lamp: lamp=%b, required 000000", lamp);
        end
        btn = '0;
        cyc(3);
        rst_n    = 1'b0;
        nz       = 0;
        bad_lamp = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (dout !== 3'd0) nz++;
            if (lamp !== 6'd0) bad_lamp++;
        end
        tests_run++;
        if (nz != 0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: %0d nonzero dout cycles, required 0", nz);
        end
        tests_run++;
        if (bad_lamp != 0) begin
            tests_failed++;
            $display("FAIL lamp_after_reset: %0d lit lamp cycles, required 0", bad_lamp);
        end
    endtask

    task automatic test_debounce;
        bit ok;
        exp_q.push_back(3'd3);
        btn[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(2);
            btn[2] = ~btn[2];
        end
        btn[2] = 1'b1;
        wait_drain(80, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL debounce_issue: %0d codes outstanding, required 0", exp_q.size());
        end
        cyc(40);
        tests_run++;
        if (lamp !== 6'b000100) begin
            tests_failed++;
            $display("FAIL debounce_lamp: lamp=%b, required 000100", lamp);
        end
        arrive(3'd3);
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL arrival_lamp: lamp=%b, required 000000", lamp);
        end
        btn[2] = 1'b0;
        cyc(40);
        // Glitch spans at most two samples.
        btn[0] = 1'b1;
        cyc(5);
        btn[0] = 1'b0;
        cyc(60);
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL glitch_lamp: lamp=%b, required 000000", lamp);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        exp_q.push_back(3'd5);
        btn[4] = 1'b1;
        wait_drain(80, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rr_setup: %0d codes outstanding, required 0", exp_q.size());
        end
        arrive(3'd5);
        btn[4] = 1'b0;
        cyc(40);
        // last is now 5, so the search starts at 6 and wraps.
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd5);
        btn = 6'b110010;
        wait_drain(120, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL rr_order: %0d codes outstanding, required 0", exp_q.size());
        end
        cyc(5);
        tests_run++;
        if (lamp !== 6'b110010) begin
            tests_failed++;
            $display("FAIL rr_lamp: lamp=%b, required 110010", lamp);
        end
        arrive(3'd6);
        arrive(3'd2);
        arrive(3'd5);
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL rr_clear: lamp=%b, required 000000", lamp);
        end
        btn = '0;
        cyc(40);
    endtask

    task automatic test_duplicate;
        bit ok;
        exp_q.push_back(3'd4);
        btn[3] = 1'b1;
        wait_drain(80, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL dup_first: %0d codes outstanding, required 0", exp_q.size());
        end
        btn[3] = 1'b0;
        cyc(40);
        btn[3] = 1'b1;
        cyc(60);
        tests_run++;
        if (lamp !== 6'b001000) begin
            tests_failed++;
            $display("FAIL dup_lamp: lamp=%b, required 001000", lamp);
        end
        arrive(3'd4);
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL dup_arrival: lamp=%b, required 000000", lamp);
        end
        btn[3] = 1'b0;
        cyc(40);
        exp_q.push_back(3'd4);
        btn[3] = 1'b1;
        wait_drain(80, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL dup_reissue: %0d codes outstanding, required 0", exp_q.size());
        end
        cyc(3);
        arrive(3'd4);
        btn[3] = 1'b0;
        cyc(40);
    endtask

    task automatic test_backpressure;
        bit ok;
        q_full = 1'b1;
        btn[0] = 1'b1;
        cyc(60);
        tests_run++;
        if (dout !== 3'd0) begin
            tests_failed++;
            $display("FAIL bp_hold_dout: dout=%0d, required 0", dout);
        end
        tests_run++;
        if (lamp !== 6'b000001) begin
            tests_failed++;
            $display("FAIL bp_hold_lamp: lamp=%b, required 000001", lamp);
        end
        // Just after edge k.
        exp_q.push_back(3'd1);
        q_full = 1'b0;
        tests_run++;
        if (dout !== 3'd0) begin
            tests_failed++;
            $display("FAIL bp_edge_k: dout=%0d, required 0", dout);
        end
        cyc(1);
        tests_run++;
        if (dout !== 3'd1) begin
            tests_failed++;
            $display("FAIL bp_edge_k1: dout=%0d, required 1", dout);
        end
        // Raising q_full during ISSUE must not abort it.
        q_full = 1'b1;
        cyc(1);
        wait_drain(10, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_issue: %0d codes outstanding, required 0", exp_q.size());
        end
        tests_run++;
        if (lamp !== 6'b000001) begin
            tests_failed++;
            $display("FAIL bp_issued_lamp: lamp=%b, required 000001", lamp);
        end
        arrive(3'd1);
        q_full = 1'b0;
        btn[0] = 1'b0;
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL bp_clear: lamp=%b, required 000000", lamp);
        end
        cyc(40);
    endtask

    task automatic test_simultaneous;
        bit ok;
        int bad;
        // Arrival for floor 2 covers every cycle in which its press can land.
        arr_valid = 1'b1;
        arr_floor = 3'd2;
        btn[1]    = 1'b1;
        bad       = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (lamp[1] !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL same_cycle_press: lamp[1] lit %0d cycles, required 0", bad);
        end
        arr_valid = 1'b0;
        arr_floor = 3'd0;
        cyc(60);
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL press_dropped: lamp=%b, required 000000", lamp);
        end
        btn[1] = 1'b0;
        cyc(40);
        // Floor 6 issued, floor 3 held pending, then invalid arrivals.
        exp_q.push_back(3'd6);
        btn[5] = 1'b1;
        wait_drain(80, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL sim_setup: %0d codes outstanding, required 0", exp_q.size());
        end
        q_full = 1'b1;
        btn[2] = 1'b1;
        cyc(60);
        tests_run++;
        if (lamp !== 6'b100100) begin
            tests_failed++;
            $display("FAIL sim_pending: lamp=%b, required 100100", lamp);
        end
        arr_valid = 1'b1;
        arr_floor = 3'd0;
        cyc(1);
        arr_floor = 3'd7;
        cyc(1);
        arr_valid = 1'b0;
        arr_floor = 3'd0;
        cyc(2);
        tests_run++;
        if (lamp !== 6'b100100) begin
            tests_failed++;
            $display("FAIL invalid_arrival: lamp=%b, required 100100", lamp);
        end
        arrive(3'd6);
        tests_run++;
        if (lamp !== 6'b000100) begin
            tests_failed++;
            $display("FAIL valid_arrival: lamp=%b, required 000100", lamp);
        end
        exp_q.push_back(3'd3);
        q_full = 1'b0;
        wait_drain(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL sim_release: %0d codes outstanding, required 0", exp_q.size());
        end
        cyc(3);
        arrive(3'd3);
        btn = '0;
        tests_run++;
        if (lamp !== 6'd0) begin
            tests_failed++;
            $display("FAIL sim_clear: lamp=%b, required 000000", lamp);
        end
    endtask

    initial begin
        btn       = '0;
        q_full    = 1'b0;
        arr_valid = 1'b0;
        arr_floor = 3'd0;
        rst_n     = 1'b0;
        #1;
        rst_n     = 1'b1;
        #1;
        test_reset();
        test_debounce();
        test_round_robin();
        test_duplicate();
        test_backpressure();
        test_simultaneous();
        cyc(20);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL final_drain: %0d codes outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
